// File: rtl/jtag_bsr_out.sv
// Output boundary-scan register: data cells plus per-group output-enable cells,
// with a bypass flop that takes over the serial path under clamp/highz.
module jtag_bsr_out #(
    parameter int               WIDTH      = 8,
    parameter int               NUM_OE     = 2,
    parameter logic [WIDTH-1:0] SAFE_VALUE = {WIDTH{1'b0}}
) (
    input  logic              TCK,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  FromCore,
    input  logic [NUM_OE-1:0] FromCoreOE,
    input  logic              FromPreviousBSCell,
    input  logic              Select,
    input  logic              CaptureDR,
    input  logic              ShiftDR,
    input  logic              UpdateDR,
    input  logic              extest,
    input  logic              clamp,
    input  logic              highz,
    output logic [WIDTH-1:0]  Pin,
    output logic [WIDTH-1:0]  PinOE,
    output logic              ToNextBSCell
);

    localparam int L   = WIDTH + NUM_OE;
    localparam int GRP = WIDTH / NUM_OE;

    logic [L-1:0]      srReg;
    logic [L-1:0]      srNext;
    logic              byReg;
    logic              byNext;
    logic [WIDTH-1:0]  urDataReg;
    logic [WIDTH-1:0]  urDataNext;
    logic [NUM_OE-1:0] urOeReg;
    logic [NUM_OE-1:0] urOeNext;
    logic              bypassMode;
    logic              scanMode;

    // clamp and highz both route the serial path through the single bypass flop
    assign bypassMode = clamp | highz;
    assign scanMode   = extest | bypassMode;

    // Capture/shift side. Capture has priority over shift.
    always_comb begin
        srNext = srReg;
        byNext = byReg;
        if (Select) begin
            if (bypassMode) begin
                if (CaptureDR) begin
                    byNext = 1'b0;
                end else if (ShiftDR) begin
                    byNext = FromPreviousBSCell;
                end
            end else begin
                if (CaptureDR) begin
                    srNext = {FromCoreOE, FromCore};
                end else if (ShiftDR) begin
                    srNext = {FromPreviousBSCell, srReg[L-1:1]};
                end
            end
        end
    end

    always_ff @(posedge TCK or posedge Reset) begin
        if (Reset) begin
            srReg <= '0;
            byReg <= 1'b0;
        end else begin
            srReg <= srNext;
            byReg <= byNext;
        end
    end

    // Update side runs on the falling edge so pins change mid-cycle after Update-DR.
    always_comb begin
        urDataNext = urDataReg;
        urOeNext   = urOeReg;
        if (Select && UpdateDR && !bypassMode) begin
            urDataNext = srReg[WIDTH-1:0];
            urOeNext   = srReg[L-1:WIDTH];
        end
    end

    always_ff @(negedge TCK or posedge Reset) begin
        if (Reset) begin
            urDataReg <= SAFE_VALUE;
            urOeReg   <= '0;
        end else begin
            urDataReg <= urDataNext;
            urOeReg   <= urOeNext;
        end
    end

    assign ToNextBSCell = bypassMode ? byReg : srReg[0];

    // Per-pin muxing; each pin follows the enable of its group.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
            localparam int G = gi / GRP;
            always_comb begin
                Pin[gi]   = FromCore[gi];
                PinOE[gi] = FromCoreOE[G];
                if (scanMode) begin
                    Pin[gi]   = urDataReg[gi];
                    PinOE[gi] = highz ? 1'b0 : urOeReg[G];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_jtag_bsr_out.sv
// Scoreboard bench for jtag_bsr_out (WIDTH=8, NUM_OE=2, SAFE_VALUE=8'hA5).
module tb_jtag_bsr_out;

    logic       TCK = 1'b0;
    logic       Reset;
    logic [7:0] FromCore;
    logic [1:0] FromCoreOE;
    logic       FromPreviousBSCell;
    logic       Select, CaptureDR, ShiftDR, UpdateDR;
    logic       extest, clamp, highz;
    logic [7:0] Pin, PinOE;
    logic       ToNextBSCell;

    jtag_bsr_out #(.WIDTH(8), .NUM_OE(2), .SAFE_VALUE(8'hA5)) dut (
        .TCK(TCK), .Reset(Reset), .FromCore(FromCore), .FromCoreOE(FromCoreOE),
        .FromPreviousBSCell(FromPreviousBSCell), .Select(Select),
        .CaptureDR(CaptureDR), .ShiftDR(ShiftDR), .UpdateDR(UpdateDR),
        .extest(extest), .clamp(clamp), .highz(highz),
        .Pin(Pin), .PinOE(PinOE), .ToNextBSCell(ToNextBSCell)
    );

    always #5 TCK = ~TCK;

    typedef struct {
        string      name;
        int         kind;   // 0 = Pin, 1 = PinOE, 2 = ToNextBSCell
        logic [7:0] exp;
    } exp_t;

    exp_t sbQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    event sampleEv;

    // Monitor: whenever the stimulus marks the outputs as presentable, drain the queue.
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(sampleEv);
            while (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                case (e.kind)
                    0:       act = Pin;
                    1:       act = PinOE;
                    default: act = {7'b0, ToNextBSCell};
                endcase
                compared++;
                if (act !== e.exp) begin
                    mismatched++;
                    $display("FAIL %s: got %h, required %h (t=%0t)", e.name, act, e.exp, $time);
                end else begin
                    $display("ok   %s: %h (t=%0t)", e.name, act, $time);
                end
            end
        end
    end

    task automatic expectOut(input string name, input int kind, input logic [7:0] v);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = v;
        sbQ.push_back(e);
        -> sampleEv;
        #1;
    endtask

    task automatic tick();
        @(posedge TCK);
        #1;
    endtask

    // Shift L bits out, checking ToNextBSCell before each shift edge.
    task automatic shiftOutCheck(input string name, input logic [9:0] bits, input logic tdi);
        for (int i = 0; i < 10; i++) begin
            expectOut($sformatf("%s[%0d]", name, i), 2, {7'b0, bits[i]});
            FromPreviousBSCell = tdi;
            ShiftDR = 1'b1;
            tick();
        end
        ShiftDR = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, required completion");
        $fatal(1);
    end

    initial begin
        logic [9:0] pat;
        Reset = 1'b1; FromCore = 8'h00; FromCoreOE = 2'b00; FromPreviousBSCell = 1'b0;
        Select = 1'b0; CaptureDR = 1'b0; ShiftDR = 1'b0; UpdateDR = 1'b0;
        extest = 1'b0; clamp = 1'b0; highz = 1'b0;
        #12 Reset = 1'b0;
        tick();

        // Reset state under extest
        extest = 1'b1;
        #1;
        expectOut("rst_pin", 0, 8'hA5);
        expectOut("rst_oe", 1, 8'h00);
        expectOut("rst_tdo", 2, 8'h00);

        // Functional mode and capture of core values
        extest = 1'b0; FromCore = 8'h3C; FromCoreOE = 2'b10; Select = 1'b1;
        #1;
        expectOut("func_pin", 0, 8'h3C);
        expectOut("func_oe", 1, 8'hF0);
        CaptureDR = 1'b1;
        tick();
        CaptureDR = 1'b0;
        shiftOutCheck("cap_out", 10'b10_0011_1100, 1'b0);

        // Extest load of {01, F0}
        extest = 1'b1;
        pat = 10'b01_1111_0000;
        for (int i = 0; i < 10; i++) begin
            FromPreviousBSCell = pat[i];
            ShiftDR = 1'b1;
            tick();
        end
        ShiftDR = 1'b0;
        expectOut("pre_upd_pin", 0, 8'hA5);
        UpdateDR = 1'b1;
        #1;
        expectOut("pre_neg_pin", 0, 8'hA5);
        expectOut("pre_neg_oe", 1, 8'h00);
        @(negedge TCK);
        #1;
        expectOut("ext_pin", 0, 8'hF0);
        expectOut("ext_oe", 1, 8'h0F);
        UpdateDR = 1'b0;
        tick();

        // Clamp: bypass flop in the chain, update ignored
        clamp = 1'b1;
        #1;
        expectOut("clamp_pin", 0, 8'hF0);
        expectOut("clamp_oe", 1, 8'h0F);
        CaptureDR = 1'b1;
        tick();
        CaptureDR = 1'b0;
        expectOut("clamp_cap_tdo", 2, 8'h00);
        FromPreviousBSCell = 1'b1; ShiftDR = 1'b1;
        tick();
        ShiftDR = 1'b0;
        expectOut("clamp_shift_tdo", 2, 8'h01);
        UpdateDR = 1'b1;
        tick();
        UpdateDR = 1'b0;
        expectOut("clamp_upd_pin", 0, 8'hF0);
        expectOut("clamp_upd_oe", 1, 8'h0F);

        // Highz: outputs disabled at once; deselected activity leaves BY alone
        clamp = 1'b0; highz = 1'b1;
        #1;
        expectOut("hz_oe", 1, 8'h00);
        expectOut("hz_pin", 0, 8'hF0);
        expectOut("hz_tdo", 2, 8'h01);
        Select = 1'b0; FromPreviousBSCell = 1'b0; CaptureDR = 1'b1;
        tick();
        CaptureDR = 1'b0;
        expectOut("hz_desel_tdo", 2, 8'h01);

        // Deselected full capture/shift/update in extest: nothing moves
        highz = 1'b0; FromCore = 8'h00; FromCoreOE = 2'b11;
        CaptureDR = 1'b1;
        tick();
        CaptureDR = 1'b0;
        for (int i = 0; i < 10; i++) begin
            FromPreviousBSCell = 1'b1; ShiftDR = 1'b1;
            tick();
        end
        ShiftDR = 1'b0; UpdateDR = 1'b1;
        tick();
        UpdateDR = 1'b0;
        expectOut("desel_pin", 0, 8'hF0);
        expectOut("desel_oe", 1, 8'h0F);
        Select = 1'b1;
        shiftOutCheck("desel_sr", 10'b01_1111_0000, 1'b0);

        // Reset between 5th and 6th shift
        for (int i = 0; i < 5; i++) begin
            FromPreviousBSCell = 1'b1; ShiftDR = 1'b1;
            tick();
        end
        ShiftDR = 1'b0;
        #2 Reset = 1'b1;
        #1;
        expectOut("midrst_tdo", 2, 8'h00);
        expectOut("midrst_pin", 0, 8'hA5);
        expectOut("midrst_oe", 1, 8'h00);
        Reset = 1'b0;
        tick();
        shiftOutCheck("post_rst_sr", 10'b00_0000_0000, 1'b0);

        // Capture beats shift when both are asserted
        FromCore = 8'h81; FromCoreOE = 2'b01;
        CaptureDR = 1'b1; ShiftDR = 1'b1; FromPreviousBSCell = 1'b0;
        tick();
        CaptureDR = 1'b0; ShiftDR = 1'b0;
        shiftOutCheck("cap_wins", 10'b01_1000_0001, 1'b0);

        #20;
        if (sbQ.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sbQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
